// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one word per line.
// Read hits complete combinationally; misses and all writes stall while a req/ack memory transaction runs.
module data_cache #(
    parameter int NBITS   = 8,
    parameter int NLINES  = 4,
    parameter int CNTBITS = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NBITS-1:2]   Address,
    input  logic [NBITS-1:0]   WriteData,
    input  logic               MemRead,
    input  logic               MemWrite,
    output logic [NBITS-1:0]   ReadData,
    output logic               Stall,
    output logic               mem_req,
    output logic               mem_we,
    output logic [NBITS-1:2]   mem_addr,
    output logic [NBITS-1:0]   mem_wdata,
    input  logic [NBITS-1:0]   mem_rdata,
    input  logic               mem_ack,
    output logic [CNTBITS-1:0] hits,
    output logic [CNTBITS-1:0] misses,
    output logic [1:0]         state_dbg
);

    localparam int IW  = $clog2(NLINES);
    localparam int TW  = NBITS - 2 - IW;
    localparam int TWS = (TW > 0) ? TW : 1;

    // Handshake: mem_req rises on FILL/WRITE entry and holds until the cycle mem_ack is
    // sampled high; mem_we/mem_addr/mem_wdata are stable for the whole request.
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_RESP} state_t;

    state_t             state;
    logic               line_valid [NLINES];
    logic [TWS-1:0]     line_tag   [NLINES];
    logic [NBITS-1:0]   line_data  [NLINES];
    logic [NBITS-1:0]   resp_data;
    logic               resp_is_read;

    logic [IW-1:0]      req_idx, fill_idx;
    logic [TWS-1:0]     req_tag, fill_tag;
    logic               hit;

    assign req_idx  = Address[IW+1:2];
    assign fill_idx = mem_addr[IW+1:2];

    // With a single full-address-sized index there is no tag; a constant tag keeps compares uniform.
    if (TW > 0) begin : g_tag
        assign req_tag  = Address[NBITS-1:IW+2];
        assign fill_tag = mem_addr[NBITS-1:IW+2];
    end else begin : g_notag
        assign req_tag  = '0;
        assign fill_tag = '0;
    end

    assign hit       = line_valid[req_idx] && (line_tag[req_idx] == req_tag);
    assign state_dbg = state;

    always_comb begin
        Stall    = 1'b0;
        ReadData = '0;
        case (state)
            S_IDLE: begin
                if (MemWrite) begin
                    Stall = 1'b1;
                end else if (MemRead) begin
                    if (hit) ReadData = line_data[req_idx];
                    else     Stall    = 1'b1;
                end
            end
            S_FILL, S_WRITE: Stall = 1'b1;
            S_RESP: if (resp_is_read) ReadData = resp_data;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            hits         <= '0;
            misses       <= '0;
            resp_data    <= '0;
            resp_is_read <= 1'b0;
            for (int i = 0; i < NLINES; i++) begin
                line_valid[i] <= 1'b0;
                line_tag[i]   <= '0;
                line_data[i]  <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (MemWrite) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= Address;
                        mem_wdata <= WriteData;
                        if (hit) line_data[req_idx] <= WriteData;
                        state     <= S_WRITE;
                    end else if (MemRead) begin
                        if (hit) begin
                            if (hits != '1) hits <= hits + 1'b1;
                        end else begin
                            if (misses != '1) misses <= misses + 1'b1;
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= Address;
                            state    <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (mem_ack) begin
                        line_valid[fill_idx] <= 1'b1;
                        line_tag[fill_idx]   <= fill_tag;
                        line_data[fill_idx]  <= mem_rdata;
                        resp_data            <= mem_rdata;
                        resp_is_read         <= 1'b1;
                        mem_req              <= 1'b0;
                        state                <= S_RESP;
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        mem_req      <= 1'b0;
                        mem_we       <= 1'b0;
                        resp_is_read <= 1'b0;
                        state        <= S_RESP;
                    end
                end
                S_RESP: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboarded bench for data_cache: drivers push expected responses, a monitor and a memory
// responder pop and compare whenever the DUT completes a request or opens a memory transaction.
module tb_data_cache;

    localparam int NBITS   = 8;
    localparam int NLINES  = 4;
    localparam int CNTBITS = 8;

    typedef struct packed {
        logic       we;
        logic [5:0] addr;
        logic [7:0] wdata;
    } mem_txn_t;

    logic               clock = 1'b0;
    logic               reset;
    logic [NBITS-1:2]   Address;
    logic [NBITS-1:0]   WriteData;
    logic               MemRead, MemWrite;
    logic [NBITS-1:0]   ReadData;
    logic               Stall;
    logic               mem_req, mem_we;
    logic [NBITS-1:2]   mem_addr;
    logic [NBITS-1:0]   mem_wdata, mem_rdata;
    logic               mem_ack;
    logic [CNTBITS-1:0] hits, misses;
    logic [1:0]         state_dbg;

    logic [7:0]  exp_q[$];
    mem_txn_t    mem_exp_q[$];
    logic [7:0]  mem_model [64];
    int          lat;
    int          n_checks = 0;
    int          n_pass   = 0;

    data_cache #(.NBITS(NBITS), .NLINES(NLINES), .CNTBITS(CNTBITS)) dut (
        .clock(clock), .reset(reset), .Address(Address), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(ReadData), .Stall(Stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hits(hits), .misses(misses),
        .state_dbg(state_dbg)
    );

    // clock / watchdog
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // monitor: a request completes in any cycle where it is asserted and Stall is low
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clock);
            if (!reset && (MemRead || MemWrite) && !Stall) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_response: got ReadData 0x%0h with empty queue", ReadData);
                end else begin
                    e = exp_q.pop_front();
                    check("ReadData", ReadData, e);
                end
            end
        end
    end

    // memory responder: ack 'lat' cycles after a request is first seen
    initial begin
        logic       in_txn, t_we;
        logic [5:0] t_addr;
        logic [7:0] t_wd;
        int         wcnt;
        mem_txn_t   m;
        in_txn = 1'b0;
        wcnt = 0;
        t_we = 1'b0; t_addr = '0; t_wd = '0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clock);
            #1;
            mem_ack = 1'b0;
            if (mem_req && !in_txn) begin
                in_txn = 1'b1;
                wcnt   = lat - 1;
                t_we   = mem_we;
                t_addr = mem_addr;
                t_wd   = mem_wdata;
                if (mem_exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_mem_req: got addr 0x%0h we %0b with empty queue", t_addr, t_we);
                end else begin
                    m = mem_exp_q.pop_front();
                    check("mem_we", {31'd0, t_we}, {31'd0, m.we});
                    check("mem_addr", {26'd0, t_addr}, {26'd0, m.addr});
                    if (m.we) check("mem_wdata", {24'd0, t_wd}, {24'd0, m.wdata});
                end
            end
            if (in_txn) begin
                if (wcnt == 0) begin
                    mem_ack = 1'b1;
                    if (t_we) mem_model[t_addr] = t_wd;
                    else      mem_rdata = mem_model[t_addr];
                    in_txn = 1'b0;
                end else begin
                    wcnt--;
                end
            end
        end
    end

    task automatic wait_done(input int exp_stall);
        int cnt;
        cnt = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (!Stall) break;
            cnt++;
        end
        check("stall_cycles", cnt, exp_stall);
        if (exp_stall > 0) check("mem_req_after_ack", {31'd0, mem_req}, 32'd0);
    endtask

    task automatic do_read(input logic [5:0] addr, input logic [7:0] exp_data, input int exp_stall);
        @(posedge clock);
        #1;
        Address = addr;
        MemRead = 1'b1;
        exp_q.push_back(exp_data);
        if (exp_stall > 0) mem_exp_q.push_back('{we: 1'b0, addr: addr, wdata: 8'h00});
        wait_done(exp_stall);
        @(posedge clock);
        #1;
        MemRead = 1'b0;
    endtask

    task automatic do_write(input logic [5:0] addr, input logic [7:0] data, input int exp_stall,
                            input logic with_read);
        @(posedge clock);
        #1;
        Address   = addr;
        WriteData = data;
        MemWrite  = 1'b1;
        MemRead   = with_read;
        exp_q.push_back(8'h00);
        mem_exp_q.push_back('{we: 1'b1, addr: addr, wdata: data});
        wait_done(exp_stall);
        @(posedge clock);
        #1;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
    endtask

    task automatic check_counters(input int exp_hits, input int exp_misses);
        check("hits", {24'd0, hits}, exp_hits);
        check("misses", {24'd0, misses}, exp_misses);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem_model[i] = 8'h00;
        mem_model[6'h01] = 8'h11;
        mem_model[6'h02] = 8'h22;
        mem_model[6'h03] = 8'h33;
        mem_model[6'h05] = 8'hA5;
        mem_model[6'h06] = 8'h66;
        lat       = 1;
        reset     = 1'b1;
        Address   = '0;
        WriteData = '0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", {26'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        check("rst_ReadData", {24'd0, ReadData}, 32'd0);
        check("rst_Stall", {31'd0, Stall}, 32'd0);
        check_counters(0, 0);
        @(posedge clock);
        #1 reset = 1'b0;

        // miss then hit on 0x05
        do_read(6'h05, 8'hA5, 2);
        check_counters(0, 1);
        do_read(6'h05, 8'hA5, 0);
        check_counters(1, 1);

        // write hit updates line; write miss does not allocate
        do_write(6'h05, 8'h3C, 2, 1'b0);
        check_counters(1, 1);
        do_read(6'h05, 8'h3C, 0);
        lat = 3;
        do_write(6'h06, 8'h77, 4, 1'b0);
        do_read(6'h06, 8'h77, 4);
        check_counters(2, 2);

        // conflict on index 1
        lat = 1;
        do_read(6'h01, 8'h11, 2);
        do_read(6'h05, 8'h3C, 2);
        do_read(6'h01, 8'h11, 2);
        do_read(6'h06, 8'h77, 0);
        check_counters(3, 5);

        // MemRead and MemWrite together: write only
        do_write(6'h02, 8'h5A, 2, 1'b1);
        check_counters(3, 5);
        do_read(6'h02, 8'h5A, 2);
        check_counters(3, 6);

        // reset during FILL: mem_req drops at once, late ack ignored
        lat = 5;
        @(posedge clock);
        #1;
        Address = 6'h03;
        MemRead = 1'b1;
        mem_exp_q.push_back('{we: 1'b0, addr: 6'h03, wdata: 8'h00});
        @(posedge clock);
        #2;
        check("fill_entry_mem_req", {31'd0, mem_req}, 32'd1);
        reset   = 1'b1;
        MemRead = 1'b0;
        #1;
        check("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (6) @(posedge clock);
        @(negedge clock);
        check("late_ack_mem_req", {31'd0, mem_req}, 32'd0);
        check("late_ack_Stall", {31'd0, Stall}, 32'd0);
        check_counters(0, 0);
        lat = 1;
        do_read(6'h03, 8'h33, 2);
        check_counters(0, 1);

        // saturating hit counter
        for (int n = 0; n < 260; n++) begin
            repeat ($urandom_range(0, 1)) @(posedge clock);
            do_read(6'h03, 8'h33, 0);
        end
        check_counters(255, 1);

        repeat (3) @(posedge clock);
        check("exp_q_drained", exp_q.size(), 0);
        check("mem_exp_q_drained", mem_exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
